// File: rtl/nonogram_pkg.sv
// rtl/nonogram_pkg.sv - shared states, LED bit map and board size defaults for the solve sequencer
package nonogram_pkg;

  typedef enum logic [1:0] {
    ST_RECEIVE  = 2'd0,
    ST_SOLVE    = 2'd1,
    ST_TRANSMIT = 2'd2,
    ST_ERROR    = 2'd3
  } seq_state_t;

  localparam int LED_STATE_LSB = 0;
  localparam int LED_STATE_MSB = 1;
  localparam int LED_OVERFLOW  = 2;
  localparam int LED_TIMEOUT   = 3;
  localparam int LED_LINES     = 4;
  localparam int LED_BOARD_LSB = 5;
  localparam int LED_BOARD_MSB = 6;
  localparam int LED_HEARTBEAT = 7;

  localparam int MAX_ROWS = 11;
  localparam int MAX_COLS = 11;

endpackage

// File: rtl/watchdog_timer.sv
// rtl/watchdog_timer.sv - free-running cycle counter flagging its last count before wrapping
module watchdog_timer #(
  parameter int LIMIT = 100
) (
  input  logic clk_100mhz,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] count;

  // Wraps on its last count so the same block can serve as a periodic tick.
  always_ff @(posedge clk_100mhz) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/solve_sequencer.sv
// rtl/solve_sequencer.sv - receive/solve/transmit sequencer arbitrating FIFO writes between parser and solver
module solve_sequencer
  import nonogram_pkg::*;
#(
  parameter int LINE_W           = 16,
  parameter int TIMEOUT_CYCLES   = 100_000_000,
  parameter int HEARTBEAT_CYCLES = 50_000_000,
  parameter int MAX_LINES        = 22
) (
  input  logic                           clk_100mhz,
  input  logic                           rst,
  input  logic                           parse_write,
  input  logic [LINE_W-1:0]              parse_line,
  input  logic                           parsed,
  input  logic                           solve_write,
  input  logic [LINE_W-1:0]              solve_line,
  input  logic                           solved,
  input  logic                           assembled,
  input  logic                           fifo_full,
  input  logic [$clog2(MAX_LINES+1)-1:0] expected_lines,
  output logic                           fifo_wr_en,
  output logic [LINE_W-1:0]              fifo_din,
  output logic                           solve_start,
  output logic                           assemble_start,
  output logic [1:0]                     state_out,
  output logic [7:0]                     led
);

  localparam int LCW = $clog2(MAX_LINES + 1);

  seq_state_t     state;
  logic [LCW-1:0] line_cnt;
  logic [2:0]     board_cnt;
  logic           flag_overflow;
  logic           flag_timeout;
  logic           flag_lines;
  logic           heartbeat;

  logic sel_write;
  logic overflow_hit;
  logic wd_enable;
  logic wd_clear;
  logic wd_expired;
  logic hb_tick;

  always_comb begin
    sel_write = 1'b0;
    fifo_din  = '0;
    case (state)
      ST_RECEIVE: begin
        sel_write = parse_write;
        fifo_din  = parse_line;
      end
      ST_SOLVE: begin
        sel_write = solve_write;
        fifo_din  = solve_line;
      end
      default: ;
    endcase
  end

  assign overflow_hit = sel_write & fifo_full;
  assign fifo_wr_en   = sel_write & ~fifo_full;

  // Clear on every cycle that leaves the current state so each timed state starts at zero.
  assign wd_enable = (state == ST_SOLVE) || (state == ST_TRANSMIT);
  assign wd_clear  = !wd_enable || overflow_hit ||
                     ((state == ST_SOLVE) && solved) ||
                     ((state == ST_TRANSMIT) && assembled);

  watchdog_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_100mhz (clk_100mhz),
    .rst        (rst),
    .clear      (wd_clear),
    .enable     (wd_enable),
    .expired    (wd_expired)
  );

  watchdog_timer #(
    .LIMIT (HEARTBEAT_CYCLES)
  ) u_heartbeat (
    .clk_100mhz (clk_100mhz),
    .rst        (rst),
    .clear      (1'b0),
    .enable     (1'b1),
    .expired    (hb_tick)
  );

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      state          <= ST_RECEIVE;
      line_cnt       <= '0;
      board_cnt      <= '0;
      flag_overflow  <= 1'b0;
      flag_timeout   <= 1'b0;
      flag_lines     <= 1'b0;
      heartbeat      <= 1'b0;
      solve_start    <= 1'b0;
      assemble_start <= 1'b0;
    end else begin
      solve_start    <= 1'b0;
      assemble_start <= 1'b0;
      if (hb_tick) begin
        heartbeat <= ~heartbeat;
      end
      // A rejected write is fatal regardless of any completion pulse in the same cycle.
      if (overflow_hit) begin
        state         <= ST_ERROR;
        flag_overflow <= 1'b1;
      end else begin
        case (state)
          ST_RECEIVE: begin
            if (parse_write && (line_cnt != LCW'(MAX_LINES))) begin
              line_cnt <= line_cnt + 1'b1;
            end
            if (parsed) begin
              if (line_cnt == expected_lines) begin
                state       <= ST_SOLVE;
                solve_start <= 1'b1;
              end else begin
                state      <= ST_ERROR;
                flag_lines <= 1'b1;
              end
            end
          end
          ST_SOLVE: begin
            if (solved) begin
              state          <= ST_TRANSMIT;
              assemble_start <= 1'b1;
            end else if (wd_expired) begin
              state        <= ST_ERROR;
              flag_timeout <= 1'b1;
            end
          end
          ST_TRANSMIT: begin
            if (assembled) begin
              state     <= ST_RECEIVE;
              board_cnt <= board_cnt + 1'b1;
              line_cnt  <= '0;
            end else if (wd_expired) begin
              state        <= ST_ERROR;
              flag_timeout <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign state_out = state;

  assign led[LED_STATE_MSB:LED_STATE_LSB] = state;
  assign led[LED_OVERFLOW]                = flag_overflow;
  assign led[LED_TIMEOUT]                 = flag_timeout;
  assign led[LED_LINES]                   = flag_lines;
  assign led[LED_BOARD_MSB:LED_BOARD_LSB] = board_cnt[1:0];
  assign led[LED_HEARTBEAT]               = heartbeat;

endmodule

// File: doc/solve_sequencer.md
SOLVE_SEQUENCER -- requirements
Module: solve_sequencer

Interface
REQ-001 SHALL have parameter LINE_W, default 16, FIFO line word width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100_000_000, watchdog limit for the SOLVE and TRANSMIT states.
REQ-003 SHALL have parameter HEARTBEAT_CYCLES, default 50_000_000, heartbeat LED half-period.
REQ-004 SHALL have parameter MAX_LINES, default 22, upper bound on rows plus columns.
REQ-005 Ports SHALL be, in this order:
- clk_100mhz  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- parse_write  in  1  parser has a line to push.
- parse_line  in  LINE_W  parser line word.
- parsed  in  1  board parse complete (pulse).
- solve_write  in  1  solver has a line to push back.
- solve_line  in  LINE_W  solver line word.
- solved  in  1  solve complete (pulse).
- assembled  in  1  transmit complete (pulse).
- fifo_full  in  1  FIFO full flag.
- expected_lines  in  $clog2(MAX_LINES+1)  rows+cols reported by the parser.
- fifo_wr_en  out  1  gated FIFO write enable.
- fifo_din  out  LINE_W  muxed FIFO data.
- solve_start  out  1  one-cycle pulse that starts the solver.
- assemble_start  out  1  one-cycle pulse that starts the assembler.
- state_out  out  2  current state encoding.
- led  out  8  status display.

Function
REQ-006 The FSM SHALL have states RECEIVE=0, SOLVE=1, TRANSMIT=2, ERROR=3.
REQ-007 RECEIVE SHALL go to SOLVE on parsed when line_cnt==expected_lines, and to ERROR (lines flag) on parsed otherwise.
REQ-008 SOLVE SHALL go to TRANSMIT on solved; on watchdog expiry it SHALL go to ERROR (timeout flag).
REQ-009 TRANSMIT SHALL go to RECEIVE on assembled, incrementing board_cnt (3 bits, wraps 7->0); on watchdog expiry it SHALL go to ERROR (timeout flag).
REQ-010 ERROR SHALL be sticky until rst.
REQ-011 fifo_din SHALL be parse_line in RECEIVE and solve_line in SOLVE, combinationally; it SHALL be 0 in all other states.
REQ-012 fifo_wr_en SHALL be (selected write) AND NOT fifo_full, and SHALL be 0 in TRANSMIT and ERROR.
REQ-013 A selected write while fifo_full SHALL move the FSM to ERROR (overflow flag) on the next edge; the word SHALL NOT be written.
REQ-014 line_cnt SHALL count accepted writes in RECEIVE, saturate at MAX_LINES, and clear on entry to RECEIVE.
REQ-015 solve_start SHALL be a registered pulse, high exactly one cycle, in the first cycle of SOLVE; assemble_start SHALL behave the same for the first cycle of TRANSMIT.
REQ-016 The watchdog SHALL clear on every state change and increment each cycle in SOLVE/TRANSMIT; expiry is count==TIMEOUT_CYCLES-1.
REQ-017 If a completion pulse and expiry fall in the same cycle, the completion pulse SHALL win.
REQ-018 Completion pulses that arrive in a non-matching state SHALL be ignored (e.g. solved during RECEIVE).
REQ-019 led SHALL map as: [1:0]=state, [2]=overflow, [3]=timeout, [4]=lines error, [6:5]=board_cnt[1:0], [7]=heartbeat toggle every HEARTBEAT_CYCLES.
REQ-020 state_out SHALL equal the registered state; all outputs except fifo_din/fifo_wr_en SHALL be registered.

Reset
REQ-021 On rst the following SHALL clear: state=RECEIVE, all error flags 0, line_cnt 0, board_cnt 0, watchdog 0, heartbeat counter 0, led[7]=0, solve_start=0, assemble_start=0.
REQ-022 rst mid-SOLVE or mid-TRANSMIT SHALL abort to RECEIVE with no start pulse emitted.

Structure
REQ-023 nonogram_pkg SHALL hold the state enum, the LED bit index constants, and the MAX_ROWS/MAX_COLS defaults.
REQ-024 One sub-module, watchdog_timer (parameter LIMIT; ports clear, enable, expired), SHALL implement both the watchdog and the heartbeat.

Verification
REQ-025 Nominal: 22 parse_writes, expected_lines=22, parsed -> solve_start pulse one cycle later, state_out=1; solved -> assemble_start pulse; assembled -> state 0, led[6:5]=01.
REQ-026 Line mismatch: 21 writes, expected_lines=22, parsed -> state_out=3, led[4]=1, no solve_start.
REQ-027 Overflow: fifo_full=1 with parse_write=1 -> fifo_wr_en=0, next cycle state_out=3, led[2]=1.
REQ-028 Timeout: TIMEOUT_CYCLES=100, no solved -> state_out=3 and led[3]=1 after exactly 100 cycles in SOLVE; solved on cycle 99 -> TRANSMIT.
REQ-029 Wrap and mux: 8 full boards -> board_cnt=0; solve_write during SOLVE -> fifo_din=solve_line; rst during TRANSMIT -> state 0 and all flags cleared.
